wptr_full_gen: RTL and testbench

WPTR_FULL_GEN -- requirements
Module: wptr_full_gen

---
 rtl/fifo_cdc_pkg.sv | 26 ++
 rtl/gray_ptr_cnt.sv | 35 +++
 rtl/wptr_full_gen.sv | 92 +++++++++
 tb/tb_wptr_full_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_cdc_pkg.sv
// Shared constants and Gray/binary conversions for the async FIFO write and read pointer blocks.
// Latency: pure functions and constants, no state.
// Backpressure: none.
package fifo_cdc_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int PTR_W_DEF  = ADDR_W_DEF + 1;

    // Conversions work on a fixed wide vector; callers zero-extend in and truncate out.
    localparam int PTR_W_MAX  = 32;

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended Gray input keeps the upper result bits zero, so truncation is exact.
    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray);
        logic [PTR_W_MAX-1:0] bin;
        bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_ptr_cnt.sv
// Binary + Gray pointer register pair; binary drives the RAM address, Gray crosses domains.
// Latency: address updates on the edge after inc_i, Gray pointer registered on that same edge.
// Backpressure: none; the caller gates inc_i with its own full condition.
module gray_ptr_cnt
    import fifo_cdc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PTR_W  = PTR_W_DEF
) (
    input  logic              clk_ab,
    input  logic              rst_ab,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [PTR_W-1:0]  bin_next_o,
    output logic [PTR_W-1:0]  gray_o
);

    logic [PTR_W-1:0] bin_q;

    assign bin_next_o = bin_q + PTR_W'(inc_i);
    assign addr_o     = bin_q[ADDR_W-1:0];

    // Both pointer forms advance together; Gray comes straight off a flop so the
    // synchronizer on the far side only ever sees single-bit changes.
    always_ff @(posedge clk_ab or negedge rst_ab) begin
        if (!rst_ab) begin
            bin_q  <= '0;
            gray_o <= '0;
        end else begin
            bin_q  <= bin_next_o;
            gray_o <= PTR_W'(bin2gray(PTR_W_MAX'(bin_next_o)));
        end
    end

endmodule

// File: rtl/wptr_full_gen.sv
// Async FIFO write-side pointer, full/almost-full/overflow generation (almost_full only with WPTR_AFULL_EN).
// Latency: wen_o combinational from push_i; address moves next edge; wptr_o and flags registered, 1 cycle.
// Backpressure: pushes while full_o are dropped (wen_o=0) and raise sticky overflow_o until clr_ovf_i.
module wptr_full_gen
    import fifo_cdc_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int PTR_W        = ADDR_W + 1,
    parameter int AFULL_THRESH = 4
) (
    input  logic              clk_ab,
    input  logic              rst_ab,
    input  logic              push_i,
    input  logic [PTR_W-1:0]  rq2_rptr_i,
    input  logic              clr_ovf_i,
    output logic              wen_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [PTR_W-1:0]  wptr_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              overflow_o
);

    localparam int DEPTH = 1 << ADDR_W;

    if (PTR_W != ADDR_W + 1 || AFULL_THRESH > DEPTH) begin : g_bad_cfg
        $error("wptr_full_gen: PTR_W must be ADDR_W+1 and AFULL_THRESH must not exceed DEPTH");
    end

    logic             run_q;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rptr_wrapped;

    // run_q holds off the first cycle after reset release so no write races the release edge.
    assign wen_o = push_i & ~full_o & run_q;

    gray_ptr_cnt #(
        .ADDR_W (ADDR_W),
        .PTR_W  (PTR_W)
    ) u_ptr (
        .clk_ab     (clk_ab),
        .rst_ab     (rst_ab),
        .inc_i      (wen_o),
        .addr_o     (waddr_o),
        .bin_next_o (wbin_next),
        .gray_o     (wptr_o)
    );

    // Full means the write pointer is one lap ahead: in Gray code that is the read
    // pointer with its two MSBs inverted.
    assign wgray_next   = PTR_W'(bin2gray(PTR_W_MAX'(wbin_next)));
    assign rptr_wrapped = {~rq2_rptr_i[PTR_W-1:PTR_W-2], rq2_rptr_i[PTR_W-3:0]};

    // Enable accepts from the second cycle after reset release onward.
    always_ff @(posedge clk_ab or negedge rst_ab) begin
        if (!rst_ab) run_q <= 1'b0;
        else         run_q <= 1'b1;
    end

    // Full is judged on the post-increment pointer against the current read pointer.
    always_ff @(posedge clk_ab or negedge rst_ab) begin
        if (!rst_ab) full_o <= 1'b0;
        else         full_o <= (wgray_next == rptr_wrapped);
    end

    // Sticky overflow: a dropped push sets it, clear only wins when no drop happens.
    always_ff @(posedge clk_ab or negedge rst_ab) begin
        if (!rst_ab)                overflow_o <= 1'b0;
        else if (push_i && full_o)  overflow_o <= 1'b1;
        else if (clr_ovf_i)         overflow_o <= 1'b0;
    end

`ifdef WPTR_AFULL_EN
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(DEPTH - AFULL_THRESH);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] fill_next;

    assign rbin      = PTR_W'(gray2bin(PTR_W_MAX'(rq2_rptr_i)));
    assign fill_next = wbin_next - rbin;

    // Almost-full tracks occupancy after this cycle's accept, like full_o.
    always_ff @(posedge clk_ab or negedge rst_ab) begin
        if (!rst_ab) almost_full_o <= 1'b0;
        else         almost_full_o <= (fill_next >= AFULL_LVL);
    end
`else
    assign almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// Self-checking bench for wptr_full_gen at default parameters.
module tb_wptr_full_gen;

    localparam int DEPTH        = 256;
    localparam int AFULL_THRESH = 4;
`ifdef WPTR_AFULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic       clk_ab     = 1'b0;
    logic       rst_ab     = 1'b0;
    logic       push_i     = 1'b0;
    logic [8:0] rq2_rptr_i = 9'h000;
    logic       clr_ovf_i  = 1'b0;
    logic       wen_o;
    logic [7:0] waddr_o;
    logic [8:0] wptr_o;
    logic       full_o;
    logic       almost_full_o;
    logic       overflow_o;

    wptr_full_gen #(
        .ADDR_W       (8),
        .PTR_W        (9),
        .AFULL_THRESH (AFULL_THRESH)
    ) dut (
        .clk_ab        (clk_ab),
        .rst_ab        (rst_ab),
        .push_i        (push_i),
        .rq2_rptr_i    (rq2_rptr_i),
        .clr_ovf_i     (clr_ovf_i),
        .wen_o         (wen_o),
        .waddr_o       (waddr_o),
        .wptr_o        (wptr_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_ab = ~clk_ab;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [8:0] wptr;
        logic [7:0] waddr;
        logic       full;
        logic       afull;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       p;
        logic       c;
        logic [8:0] r;
        logic       wen;
        logic [7:0] waddr;
        logic       full;
        logic       ovf;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];

    // Reference state
    logic [8:0] m_bin;
    logic       m_full;
    logic       m_ovf;
    logic       m_run;

    logic       ws;
    logic [7:0] wa;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] tb_b2g(input logic [8:0] b);
        return b ^ {1'b0, b[8:1]};
    endfunction

    function automatic logic [8:0] tb_g2b(input logic [8:0] g);
        logic [8:0] b;
        for (int i = 0; i < 9; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic cycle(input logic p, input logic c, input logic [8:0] r,
                         output logic wen_s, output logic [7:0] waddr_s);
        exp_t       e;
        logic       wen;
        logic [8:0] nbin;
        logic [8:0] fill;
        push_i     = p;
        clr_ovf_i  = c;
        rq2_rptr_i = r;
        #1;
        wen = p & ~m_full & m_run;
        chk("wen", 32'(wen_o), 32'(wen));
        chk("waddr_pre", 32'(waddr_o), 32'(m_bin[7:0]));
        wen_s   = wen_o;
        waddr_s = waddr_o;
        nbin    = m_bin + 9'(wen);
        fill    = nbin - tb_g2b(r);
        e.wptr  = tb_b2g(nbin);
        e.waddr = nbin[7:0];
        e.full  = (tb_b2g(nbin) == (r ^ 9'h180));
        e.afull = AF_EN && (fill >= 9'(DEPTH - AFULL_THRESH));
        e.ovf   = (p && m_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
        sb.push_back(e);
        m_bin  = nbin;
        m_full = e.full;
        m_ovf  = e.ovf;
        m_run  = 1'b1;
        @(negedge clk_ab);
        e = sb.pop_front();
        chk("wptr", 32'(wptr_o), 32'(e.wptr));
        chk("waddr_post", 32'(waddr_o), 32'(e.waddr));
        chk("full", 32'(full_o), 32'(e.full));
        chk("almost_full", 32'(almost_full_o), 32'(e.afull));
        chk("overflow", 32'(overflow_o), 32'(e.ovf));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wen"}, 32'(wen_o), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr_o), 32'd0);
        chk({tag, "_wptr"}, 32'(wptr_o), 32'd0);
        chk({tag, "_full"}, 32'(full_o), 32'd0);
        chk({tag, "_afull"}, 32'(almost_full_o), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    endtask

    // Asynchronous reset between clock edges with a push held high, then release on a falling edge.
    task automatic do_reset(input string tag);
        push_i = 1'b1;
        #2 rst_ab = 1'b0;
        #1 check_zero(tag);
        @(negedge clk_ab);
        rst_ab     = 1'b1;
        push_i     = 1'b0;
        clr_ovf_i  = 1'b0;
        rq2_rptr_i = 9'h000;
        m_bin  = '0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_run  = 1'b0;
    endtask

    initial begin
        logic [8:0] d1, d2, prev, cur;
        int         wraps;

        //         p     c     r       wen   waddr  full  ovf
        tbl[0] = '{1'b1, 1'b0, 9'h000, 1'b0, 8'h00, 1'b1, 1'b1};  // 257th push dropped
        tbl[1] = '{1'b1, 1'b1, 9'h000, 1'b0, 8'h00, 1'b1, 1'b1};  // set beats clear
        tbl[2] = '{1'b0, 1'b1, 9'h000, 1'b0, 8'h00, 1'b1, 1'b0};  // clear alone
        tbl[3] = '{1'b0, 1'b0, 9'h001, 1'b0, 8'h00, 1'b0, 1'b0};  // read advances, full drops
        tbl[4] = '{1'b1, 1'b0, 9'h003, 1'b1, 8'h00, 1'b0, 1'b0};  // accept + read advance together
        tbl[5] = '{1'b1, 1'b0, 9'h003, 1'b1, 8'h01, 1'b1, 1'b0};  // refill
        tbl[6] = '{1'b1, 1'b0, 9'h003, 1'b0, 8'h02, 1'b1, 1'b1};  // drop again
        tbl[7] = '{1'b0, 1'b1, 9'h003, 1'b0, 8'h02, 1'b1, 1'b0};  // clear

        m_bin = '0; m_full = 1'b0; m_ovf = 1'b0; m_run = 1'b0;

        // Power-on reset with a push already requested
        rst_ab = 1'b0;
        push_i = 1'b1;
        #3 check_zero("rst_init");
        @(negedge clk_ab);
        rst_ab = 1'b1;

        // Bring wbin to 37, then reset mid-burst
        for (int i = 0; i < 38; i++) cycle(1'b1, 1'b0, 9'h000, ws, wa);
        chk("wbin_37", 32'(waddr_o), 32'd37);
        do_reset("rst_mid");

        // Fill from empty
        cycle(1'b1, 1'b0, 9'h000, ws, wa);
        chk("no_accept_after_release", 32'(ws), 32'd0);
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, 9'h000, ws, wa);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_wptr", 32'(wptr_o), 32'h180);

        // Corner vectors from the full state
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].p, tbl[i].c, tbl[i].r, ws, wa);
            chk($sformatf("tbl%0d_wen", i), 32'(ws), 32'(tbl[i].wen));
            chk($sformatf("tbl%0d_waddr", i), 32'(wa), 32'(tbl[i].waddr));
            chk($sformatf("tbl%0d_full", i), 32'(full_o), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow_o), 32'(tbl[i].ovf));
        end

        // Almost-full threshold
        do_reset("rst_af");
        cycle(1'b0, 1'b0, 9'h000, ws, wa);
        for (int i = 0; i < 251; i++) cycle(1'b1, 1'b0, 9'h000, ws, wa);
        chk("afull_251", 32'(almost_full_o), 32'd0);
        cycle(1'b1, 1'b0, 9'h000, ws, wa);
        chk("afull_252", 32'(almost_full_o), 32'(AF_EN));

        // Gray integrity with the read pointer trailing by two cycles
        do_reset("rst_gray");
        d1 = '0; d2 = '0; prev = '0; wraps = 0;
        for (int i = 0; i < 601; i++) begin
            cycle(1'b1, 1'b0, d2, ws, wa);
            cur = wptr_o;
            if (cur != prev) begin
                chk("gray_hamming", 32'($countones(cur ^ prev)), 32'd1);
                if (prev == 9'h100 && cur == 9'h000) wraps++;
            end
            d2   = d1;
            d1   = cur;
            prev = cur;
        end
        chk("gray_wrap_seen", 32'(wraps), 32'd1);
        chk("gray_final_addr", 32'(waddr_o), 32'(600 % 256));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
